wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Consumer end of the write-back interface: the general-purpose register file that absorbs the wb_wdata / wb_wd / wb_wreg triple leaving the MEM/WB stage.
- Provides two combinational read ports to the ID stage, with same-cycle write-to-read bypass.
- Register 0 is hard-wired to zero.
- Includes a retired-write counter, used for performance and debug accounting.

Parameters:
- DATA_W, 32, register width (matches RegBus).
- ADDR_W, 5, register index width (matches RegAddrBus).
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- wb_wreg  in  1  write enable from write-back (WriteEnable = 1).
- wb_wd  in  ADDR_W  destination register index.
- wb_wdata  in  DATA_W  write data.
- re1  in  1  read-port-1 enable.
- raddr1  in  ADDR_W  read-port-1 index.
- rdata1  out  DATA_W  read-port-1 data.
- re2  in  1  read-port-2 enable.
- raddr2  in  ADDR_W  read-port-2 index.
- rdata2  out  DATA_W  read-port-2 data.
- wr_count  out  CNT_W  number of architectural writes committed since reset.

Behaviour:
Reset:
- One clock (clk). Reset rst is asynchronous, active-low.
- While rst=0: all registers 1..NUM_REGS-1 clear to 0.
- While rst=0: wr_count clears to 0.
- While rst=0: rdata1 and rdata2 are forced to 0.
- Deassertion is synchronised by the surrounding design; the block adds no reset synchroniser.

Write (rising edge of clk, rst=1):
- If wb_wreg=1 and wb_wd!=0, regs[wb_wd] <= wb_wdata.
- A write to index 0 is discarded; it does not update storage and does not count.
- Write latency: 1 cycle into storage, 0 cycles to readers via the bypass.

wr_count:
- Increments by 1 on each committed (non-discarded) write.
- Wraps from 2**CNT_W-1 to 0 with no saturation and no flag.

Read (combinational), per port n, in priority order:
1. rst=0 -> 0.
2. re_n=0 -> 0.
3. raddr_n=0 -> 0.
4. wb_wreg=1 and wb_wd==raddr_n -> wb_wdata (bypass).
5. Otherwise -> regs[raddr_n].

Boundary cases:
- Both ports may read the same index; both see the same value.
- Both ports may hit the bypass in the same cycle.
- A write to index 0 with re=1, raddr=0 still returns 0, never wb_wdata.
- If reset asserts mid-cycle coincident with a write, reset wins; no write occurs and the count stays 0.
- X on wb_wd while wb_wreg=0 must not corrupt storage.

Optional Feature:
Macro: WB_REGFILE_SCOREBOARD_EN.
- Defined:
  - Adds an output port written_map (NUM_REGS bits).
  - Bit i sets on the first committed write to register i and stays set until reset. Bit 0 is always 0.
  - Adds output uninit_rd (1 bit). It is high in any cycle where an enabled read port, with a nonzero index that does not hit the bypass, reads a register whose written_map bit is 0.
  - Both outputs are 0 during reset.
- Not defined:
  - These ports and their flops do not exist.
  - All other behaviour is identical.

Decomposition:
- Shared Defines package holds:
  - RegBus and RegAddrBus widths.
  - ZeroWord, NOPRegAddr, WriteEnable/WriteDisable, ReadEnable/ReadDisable.
  - RegNum (32).
- One natural sub-module: regfile_rd_port, instantiated twice. It contains the combinational read mux with zero/bypass priority.
- Storage and wr_count stay in the top.

Test Plan:
- Reset: hold rst=0 with garbage on all inputs -> rdata1=rdata2=0, wr_count=0. After release, reading r1..r31 returns 0.
- Write/read:
  - Cycle 0: wb_wreg=1, wb_wd=5, wb_wdata=0xDEADBEEF.
  - Cycle 1: re1=1, raddr1=5 -> rdata1=0xDEADBEEF.
  - wr_count=1.
- Bypass, same cycle: wb_wreg=1, wb_wd=7, wb_wdata=0x12345678, re1=re2=1, raddr1=raddr2=7 -> both rdata=0x12345678 in that cycle.
- Zero register: write 0xFFFFFFFF to r0, then read r0 on both ports -> 0 in the write cycle and after. wr_count is unchanged.
- Disabled read: r3=0xA5A5A5A5, re2=0, raddr2=3 -> rdata2=0.
- Counter wrap and async reset:
  - With CNT_W=4, perform 17 writes -> wr_count=1.
  - Pulse rst low between clock edges -> wr_count and all registers read 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
//------------------------------------------------------------------------------
// Module   : wb_regfile_pkg
// Brief    : Shared defines for the write-back register file slice.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wb_regfile_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int RegNum     = 32;

    localparam logic [RegBus-1:0]     ZeroWord   = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/wb_regfile_if.sv
//------------------------------------------------------------------------------
// Module   : wb_regfile_if
// Brief    : Write-back triple plus the two ID-stage read ports.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface wb_regfile_if
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus
) ();

    logic              wb_wreg;
    logic [ADDR_W-1:0] wb_wd;
    logic [DATA_W-1:0] wb_wdata;

    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;

    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;

    modport master (
        output wb_wreg, wb_wd, wb_wdata,
        output re1, raddr1, re2, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  wb_wreg, wb_wd, wb_wdata,
        input  re1, raddr1, re2, raddr2,
        output rdata1, rdata2
    );

endinterface

`default_nettype wire

// File: rtl/wb_regfile_rd_port.sv
//------------------------------------------------------------------------------
// Module   : regfile_rd_port
// Brief    : Combinational read mux: reset/disable/r0 zeroing, then bypass.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_rd_port
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = RegBus,
    parameter int ADDR_W   = RegAddrBus,
    parameter int NUM_REGS = RegNum
) (
    input  wire logic              rst,
    input  wire logic              re,
    input  wire logic [ADDR_W-1:0] raddr,
    input  wire logic              wb_wreg,
    input  wire logic [ADDR_W-1:0] wb_wd,
    input  wire logic [DATA_W-1:0] wb_wdata,
    input  wire logic [DATA_W-1:0] regs [NUM_REGS],
    output logic      [DATA_W-1:0] rdata
);

    always_comb begin
        rdata = DATA_W'(ZeroWord);
        if (!rst || re != ReadEnable || raddr == ADDR_W'(NOPRegAddr)) begin
            rdata = DATA_W'(ZeroWord);
        end else if (wb_wreg == WriteEnable && wb_wd == raddr) begin
            // Same-cycle write forwards straight to the reader.
            rdata = wb_wdata;
        end else begin
            rdata = regs[raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
//------------------------------------------------------------------------------
// Module   : wb_regfile
// Brief    : GPR file fed by write-back, two bypassed read ports, write counter.
//            Optional WB_REGFILE_SCOREBOARD_EN adds written_map / uninit_rd.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = RegBus,
    parameter int ADDR_W   = RegAddrBus,
    parameter int NUM_REGS = RegNum,
    parameter int CNT_W    = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    wb_regfile_if.slave           bus,
    output logic      [CNT_W-1:0] wr_count
`ifdef WB_REGFILE_SCOREBOARD_EN
    ,
    output logic [NUM_REGS-1:0]   written_map,
    output logic                  uninit_rd
`endif
);

    logic [DATA_W-1:0] r_regs   [1:NUM_REGS-1];
    logic [DATA_W-1:0] w_regs   [NUM_REGS];
    logic [CNT_W-1:0]  r_wr_count;
    logic              w_commit;

    // Writes to r0 are dropped entirely, so they neither store nor count.
    assign w_commit = (bus.wb_wreg == WriteEnable) &&
                      (bus.wb_wd != ADDR_W'(NOPRegAddr));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_count <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_commit && bus.wb_wd == ADDR_W'(i)) begin
                    r_regs[i] <= bus.wb_wdata;
                end
            end
            if (w_commit) begin
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_regs[0] = DATA_W'(ZeroWord);
        for (int i = 1; i < NUM_REGS; i++) begin
            w_regs[i] = r_regs[i];
        end
    end

    assign wr_count = r_wr_count;

    regfile_rd_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_rd_port1 (
        .rst      (rst),
        .re       (bus.re1),
        .raddr    (bus.raddr1),
        .wb_wreg  (bus.wb_wreg),
        .wb_wd    (bus.wb_wd),
        .wb_wdata (bus.wb_wdata),
        .regs     (w_regs),
        .rdata    (bus.rdata1)
    );

    regfile_rd_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_rd_port2 (
        .rst      (rst),
        .re       (bus.re2),
        .raddr    (bus.raddr2),
        .wb_wreg  (bus.wb_wreg),
        .wb_wd    (bus.wb_wd),
        .wb_wdata (bus.wb_wdata),
        .regs     (w_regs),
        .rdata    (bus.rdata2)
    );

`ifdef WB_REGFILE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] r_written_map;
    logic                w_uninit1;
    logic                w_uninit2;

    // Bit 0 is only ever cleared, so r0 always reports as unwritten.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_written_map <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_commit && bus.wb_wd == ADDR_W'(i)) begin
                    r_written_map[i] <= 1'b1;
                end
            end
        end
    end

    assign w_uninit1 = rst && (bus.re1 == ReadEnable) &&
                       (bus.raddr1 != ADDR_W'(NOPRegAddr)) &&
                       !(bus.wb_wreg == WriteEnable && bus.wb_wd == bus.raddr1) &&
                       !r_written_map[bus.raddr1];
    assign w_uninit2 = rst && (bus.re2 == ReadEnable) &&
                       (bus.raddr2 != ADDR_W'(NOPRegAddr)) &&
                       !(bus.wb_wreg == WriteEnable && bus.wb_wd == bus.raddr2) &&
                       !r_written_map[bus.raddr2];

    assign written_map = r_written_map;
    assign uninit_rd   = w_uninit1 || w_uninit2;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
//------------------------------------------------------------------------------
// Module   : tb_wb_regfile
// Brief    : Self-checking bench for wb_regfile (counter width 4 to reach wrap).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_regfile;
    import wb_regfile_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [CNT_W-1:0] wr_count;
    int               n_cmp = 0;
    int               n_bad = 0;
    bit               cmp_on = 1'b0;

    wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

`ifdef WB_REGFILE_SCOREBOARD_EN
    logic [31:0] written_map;
    logic        uninit_rd;
`endif

    wb_regfile #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NUM_REGS (32),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .wr_count    (wr_count)
`ifdef WB_REGFILE_SCOREBOARD_EN
        ,
        .written_map (written_map),
        .uninit_rd   (uninit_rd)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: architectural state as plain arrays.
    logic [31:0] m_regs [32];
    int          m_count;
    logic [31:0] m_written;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_count   = 0;
            m_written = '0;
        end else if (bus.wb_wreg === 1'b1 && bus.wb_wd != 5'd0) begin
            m_regs[bus.wb_wd]    = bus.wb_wdata;
            m_written[bus.wb_wd] = 1'b1;
            m_count              = m_count + 1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] ra);
        if (rst !== 1'b1) return 32'h0;
        if (re !== 1'b1) return 32'h0;
        if (ra == 5'd0) return 32'h0;
        if (bus.wb_wreg === 1'b1 && bus.wb_wd == ra) return bus.wb_wdata;
        return m_regs[ra];
    endfunction

    function automatic logic exp_uninit(input logic re, input logic [4:0] ra);
        if (rst !== 1'b1 || re !== 1'b1 || ra == 5'd0) return 1'b0;
        if (bus.wb_wreg === 1'b1 && bus.wb_wd == ra) return 1'b0;
        return !m_written[ra];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("rdata1", bus.rdata1, exp_rd(bus.re1, bus.raddr1));
            check("rdata2", bus.rdata2, exp_rd(bus.re2, bus.raddr2));
            check("wr_count", 32'(wr_count), 32'(m_count % (1 << CNT_W)));
`ifdef WB_REGFILE_SCOREBOARD_EN
            check("written_map", written_map, m_written);
            check("uninit_rd", 32'(uninit_rd),
                  32'(exp_uninit(bus.re1, bus.raddr1) || exp_uninit(bus.re2, bus.raddr2)));
`endif
        end
    end

    task automatic drive(input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                         input logic re1, input logic [4:0] ra1,
                         input logic re2, input logic [4:0] ra2);
        @(posedge clk);
        #1;
        bus.wb_wreg  = wreg;
        bus.wb_wd    = wd;
        bus.wb_wdata = wdata;
        bus.re1      = re1;
        bus.raddr1   = ra1;
        bus.re2      = re2;
        bus.raddr2   = ra2;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_count   = 0;
        m_written = '0;

        // Reset held low with garbage on every input.
        bus.wb_wreg = 1'b1; bus.wb_wd = 5'd5; bus.wb_wdata = 32'h55AA55AA;
        bus.re1 = 1'b1; bus.raddr1 = 5'd5; bus.re2 = 1'b1; bus.raddr2 = 5'd7;
        cmp_on = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_rdata1", bus.rdata1, 32'h0);
        check("rst_rdata2", bus.rdata2, 32'h0);
        check("rst_count", 32'(wr_count), 32'h0);

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1 rst = 1'b1;

        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(32 - i));
            #1 check("clr_read", bus.rdata1, 32'h0);
        end

        // Write then read next cycle.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
        #1 check("wr_rd_r5", bus.rdata1, 32'hDEADBEEF);
        check("count_1", 32'(wr_count), 32'd1);

        // Both ports bypass the same index.
        drive(1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 1'b1, 5'd7);
        #1 check("byp_p1", bus.rdata1, 32'h12345678);
        check("byp_p2", bus.rdata2, 32'h12345678);

        // r0 write is discarded and never bypassed.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
        #1 check("r0_wcyc_p1", bus.rdata1, 32'h0);
        check("r0_wcyc_p2", bus.rdata2, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
        #1 check("r0_after", bus.rdata1, 32'h0);
        check("count_2", 32'(wr_count), 32'd2);

        // Disabled port reads zero.
        drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3);
        #1 check("dis_p2", bus.rdata2, 32'h0);
        check("en_p1_r3", bus.rdata1, 32'hA5A5A5A5);

        // One port bypasses while the other reads storage.
        drive(1'b1, 5'd9, 32'hCAFEF00D, 1'b1, 5'd9, 1'b1, 5'd5);
        #1 check("mix_byp", bus.rdata1, 32'hCAFEF00D);
        check("mix_stor", bus.rdata2, 32'hDEADBEEF);

        // Unknown index with write disabled.
        drive(1'b0, 5'd0, 32'hBAD0BAD0, 1'b1, 5'd5, 1'b1, 5'd3);
        bus.wb_wd = 'x;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd3);
        #1 check("x_r5", bus.rdata1, 32'hDEADBEEF);
        check("x_r3", bus.rdata2, 32'hA5A5A5A5);
        check("count_4", 32'(wr_count), 32'd4);

        // Asynchronous reset mid-cycle, overlapping a pending write.
        drive(1'b1, 5'd11, 32'h11111111, 1'b1, 5'd5, 1'b1, 5'd9);
        #1 rst = 1'b0;
        #1 check("arst_count", 32'(wr_count), 32'h0);
        check("arst_p1", bus.rdata1, 32'h0);
        check("arst_p2", bus.rdata2, 32'h0);
        @(posedge clk);
        #1 bus.wb_wreg = 1'b0;
        bus.raddr1 = 5'd11;
        #1 rst = 1'b1;
        #1 check("arst_r11", bus.rdata1, 32'h0);
        check("arst_r9", bus.rdata2, 32'h0);
        check("arst_cnt0", 32'(wr_count), 32'h0);

        // 17 committed writes wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 5'((i % 31) + 1), 32'h01010101 * 32'(i + 1), 1'b0, 5'd0, 1'b0, 5'd0);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd17);
        #1 check("wrap_count", 32'(wr_count), 32'd1);
        check("wrap_r1", bus.rdata1, 32'h01010101);
        check("wrap_r17", bus.rdata2, 32'h11111111);

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        @(posedge clk);
        cmp_on = 1'b0;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
